// File: rtl/cfg_piso_tx_pkg.sv
// Shared definitions for the FSM configuration word serial load path
// (transmitter and receiving SIPO agree on field layout and tx states).
package cfg_piso_tx_pkg;

  localparam int unsigned CFG_WIDTH      = 27;
  localparam int unsigned JUMP_COUNT     = 5;
  localparam int unsigned JUMP_WIDTH     = 5;
  localparam int unsigned CLK_SEL_OFFSET = JUMP_COUNT * JUMP_WIDTH;
  localparam int unsigned CLK_SEL_WIDTH  = 2;

  function automatic int unsigned jump_offset(input int unsigned idx);
    return idx * JUMP_WIDTH;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/cfg_piso_tx_bit_tick_gen.sv
// Bit-period divider: while run is high, tick fires in the last of every
// DIV cycles. clear restarts the period at the first cycle.
module bit_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cfg_piso_tx.sv
// Parallel-in/serial-out transmitter for the FSM configuration word:
// shifts cfg MSB-first with one ser_en strobe per DIV-cycle bit period.
module cfg_piso_tx #(
  parameter int unsigned CFG_WIDTH = cfg_piso_tx_pkg::CFG_WIDTH,
  parameter int unsigned DIV       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CFG_WIDTH-1:0] cfg,
  output logic                 ready,
  output logic                 ser_out,
  output logic                 ser_en,
  output logic                 busy,
  output logic                 done
);

  import cfg_piso_tx_pkg::*;

  localparam int unsigned BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

  tx_state_t            state, state_next;
  logic [CFG_WIDTH-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
  logic                 accept;
  logic                 shifting;

  assign accept   = (state == TX_IDLE) && start;
  assign shifting = (state == TX_SHIFT);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .run   (shifting),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (start) state_next = TX_SHIFT;
      TX_SHIFT: if (tick && (bit_cnt == '0)) state_next = TX_DONE;
      TX_DONE:  state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // The final strobe still shifts, but the bit counter holds at zero so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= cfg;
      bit_cnt <= BW'(CFG_WIDTH - 1);
    end else if (tick) begin
      shreg <= shreg << 1;
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - BW'(1);
      end
    end
  end

  assign ready   = (state == TX_IDLE);
  assign busy    = shifting;
  assign done    = (state == TX_DONE);
  assign ser_out = shifting && shreg[CFG_WIDTH-1];
  assign ser_en  = tick;

endmodule

// File: tb/tb_cfg_piso_tx.sv
// Directed bench for cfg_piso_tx: one instance at DIV=1 (a) and one at DIV=4 (b).
module tb_cfg_piso_tx;
  import cfg_piso_tx_pkg::*;

  localparam int W = CFG_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] cfg_a = '0, cfg_b = '0;
  logic         ready_a, ser_out_a, ser_en_a, busy_a, done_a;
  logic         ready_b, ser_out_b, ser_en_b, busy_b, done_b;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           mon_on = 1'b0;

  cfg_piso_tx #(.CFG_WIDTH(W), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cfg(cfg_a), .ready(ready_a),
    .ser_out(ser_out_a), .ser_en(ser_en_a), .busy(busy_a), .done(done_a)
  );

  cfg_piso_tx #(.CFG_WIDTH(W), .DIV(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg(cfg_b), .ready(ready_b),
    .ser_out(ser_out_b), .ser_en(ser_en_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v, input logic [W-1:0] c);
    if (sel == 0) begin
      start_a = v;
      cfg_a   = c;
    end else begin
      start_b = v;
      cfg_b   = c;
    end
  endtask

  task automatic sample(input int sel, output logic r, output logic b, output logic d,
                        output logic so, output logic se);
    if (sel == 0) {r, b, d, so, se} = {ready_a, busy_a, done_a, ser_out_a, ser_en_a};
    else          {r, b, d, so, se} = {ready_b, busy_b, done_b, ser_out_b, ser_en_b};
  endtask

  // Send one frame and check every SHIFT cycle against the bit schedule;
  // poke re-asserts start with a different word mid-frame.
  task automatic send(input string tag, input int sel, input int div,
                      input logic [W-1:0] word, input bit poke);
    logic r, b, d, so, se;
    logic [W-1:0] rx;
    int strobes, done_k, ready_k, errs, last_k, idx;
    rx = '0; strobes = 0; done_k = -1; ready_k = -1; errs = 0;
    last_k = W * div;
    sample(sel, r, b, d, so, se);
    check({tag, "_ready_pre"}, r, 1);
    set_start(sel, 1'b1, word);
    step();
    set_start(sel, 1'b0, ~word);
    for (int k = 1; k <= last_k + 4; k++) begin
      sample(sel, r, b, d, so, se);
      if (k <= last_k) begin
        idx = W - 1 - (k - 1) / div;
        if (b !== 1'b1 || so !== word[idx] || se !== ((k % div) == 0)) errs++;
      end
      if (se === 1'b1) begin
        rx = {rx[W-2:0], so};
        strobes++;
      end
      if (d === 1'b1 && done_k < 0) done_k = k;
      if (r === 1'b1 && done_k >= 0) begin
        ready_k = k;
        break;
      end
      set_start(sel, poke && k == 5, (poke && k == 5) ? ~word : word ^ 27'h155_5555);
      step();
    end
    set_start(sel, 1'b0, word);
    check({tag, "_bit_sched_errs"}, errs, 0);
    check({tag, "_strobes"}, strobes, W);
    check({tag, "_loopback"}, rx, word);
    check({tag, "_done_cycle"}, done_k, last_k + 1);
    check({tag, "_ready_cycle"}, ready_k, last_k + 2);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("onehot_a", $countones({ready_a, busy_a, done_a}), 1);
      check("onehot_b", $countones({ready_b, busy_b, done_b}), 1);
      check("stray_a", (ser_en_a | ser_out_a) & ~busy_a, 0);
      check("stray_b", (ser_en_b | ser_out_b) & ~busy_b, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, b, d, so, se;
    int errs, strobes;
    logic eb, ed, er, eso;

    reset = 1'b1;
    repeat (2) step();
    check("rst_ready", {ready_a, ready_b}, 2'b11);
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_done", {done_a, done_b}, 2'b00);
    check("rst_ser", {ser_out_a, ser_en_a, ser_out_b, ser_en_b}, 4'b0000);
    reset = 1'b0;
    mon_on = 1'b1;
    step();

    send("t1", 0, 1, 27'h5A5_A5A5, 1'b0);
    step();
    send("t2", 1, 4, 27'h000_0001, 1'b0);
    step();
    send("t3", 0, 1, 27'h3C3_C3C3, 1'b1);
    step();

    set_start(0, 1'b1, 27'h2AB_CDEF);
    step();
    set_start(0, 1'b0, '0);
    repeat (13) step();
    check("t4_busy_before_reset", busy_a, 1);
    reset = 1'b1;
    step();
    check("t4_ready", ready_a, 1);
    check("t4_busy", busy_a, 0);
    check("t4_outs", {ser_en_a, ser_out_a, done_a}, 3'b000);
    reset = 1'b0;
    step();
    send("t4b", 0, 1, 27'h2AB_CDEF, 1'b0);
    step();

    errs = 0;
    strobes = 0;
    set_start(0, 1'b1, 27'h7FF_FFFF);
    step();
    cfg_a = 27'h000_0000;
    for (int k = 1; k <= 58; k++) begin
      sample(0, r, b, d, so, se);
      eb  = (k >= 1 && k <= 27) || (k >= 30 && k <= 56);
      ed  = (k == 28) || (k == 57);
      er  = (k == 29) || (k == 58);
      eso = (k >= 1 && k <= 27);
      if (b !== eb || d !== ed || r !== er || so !== eso || se !== eb) errs++;
      if (se === 1'b1) strobes++;
      if (k == 58) start_a = 1'b0;
      step();
    end
    check("t5_sched_errs", errs, 0);
    check("t5_strobes", strobes, 2 * W);
    repeat (3) step();
    check("t5_idle", ready_a, 1);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
